tc_timer: RTL and testbench
===========================

# tc_timer

Memory-mapped programmable timer/counter behind the system bridge; two instances (TC0, TC1) drive the bridge's `TC0_inter`/`TC1_inter` lines, which the CPU consumes as hardware interrupt bits 0 and 1. Software programs a preset and a control word through word-aligned load/store. The block then counts down and raises an interrupt request either once (mode 0) or periodically with auto-reload (mode 1).

## Interface
- Parameters: none (register map and encodings come from the shared package).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  30  word address `[31:2]` from the bridge; only `addr[3:2]` is decoded, and the bridge guarantees selection.
- `we`  in  1  full-word write strobe, sampled at the rising edge.
- `din`  in  32  write data.
- `dout`  out  32  read data, combinational from `addr[3:2]`.
- `irq`  out  1  interrupt request = `irq_flag & CTRL.IM`.

## Operation
- Register map, by `addr[3:2]`:
  - 00: CTRL, R/W. Bit 0 is EN, bits [2:1] are MODE, bit 3 is IM. Only bits [3:0] are stored; bits [31:4] read 0.
  - 01: PRESET, R/W, 32 bits.
  - 10: COUNT, read-only; writes are ignored.
  - 11: reserved; reads 0, writes ignored.
- MODE values: 00 is one-shot, 01 is auto-reload. Values 1x behave as 00.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD and clear `irq_flag`.
  - LOAD: COUNT ← PRESET; go to CNT.
  - CNT: if !EN, go to IDLE with COUNT held. Else if COUNT > 1, COUNT ← COUNT−1. Else COUNT ← 0, `irq_flag` ← 1, go to INT.
  - INT, mode 0: EN ← 0 and `irq_flag` stays 1.
  - INT, mode 1: `irq_flag` ← 0.
  - INT always goes to IDLE next.
- A one-shot `irq` stays high until software re-sets EN (IDLE→LOAD clears it) or clears IM.
- Writes:
  - A bus write to CTRL in the same cycle as the INT-state EN clear wins: the written value is stored.
  - A PRESET write during CNT affects only the next LOAD.
  - A CTRL write with EN=0 in any state stops counting at the next edge.
- COUNT arithmetic is unsigned 32-bit and never wraps below 0. PRESET=0 and PRESET=1 both reach INT one cycle after LOAD.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, `irq_flag`=0, so `irq`=0 and `dout` reads 0 everywhere.
- Write latency: registers update at the edge where `we`=1. Reads reflect the new value in the following cycle.
- Let E be the edge that stores EN=1 while in IDLE. LOAD is taken at E+1, COUNT=N at E+2, and INT is entered with `irq` high at E+N+2 for N≥1. For N=0 INT is entered at E+3.
- Mode 1 period: `irq` is a 1-cycle pulse every N+3 cycles (N≥1).
- Mode 0: `irq` rises at E+N+2 and holds. EN reads 0 from E+N+3.
- Reset asserted mid-count overrides everything: at that edge all state returns to reset values, and pending irq is dropped.

## Structure
- Shared package `tc_pkg` holds:
  - state encoding (2-bit enum IDLE/LOAD/CNT/INT);
  - register offsets (CTRL=2'b00, PRESET=2'b01, COUNT=2'b10);
  - CTRL bit positions (EN=0, MODE=[2:1], IM=3);
  - MODE constants.
- Single flat module; no sub-module. Address decode, register file, FSM and output mux live in one block.
- The bridge instantiates two copies and maps TC0/TC1 by address range.

## Test plan
- Reset: drive `reset`=1 for 2 cycles with random bus writes → all reads 0 and `irq`=0 throughout.
- One-shot: write PRESET=5, then CTRL=0x9 (EN, mode 0, IM) at edge E.
  - Expected: COUNT reads 5,4,3,2,1 on successive cycles, and `irq` rises after edge E+7 and stays high.
  - Expected: CTRL reads 0x8 from E+8.
  - Rewrite CTRL=0x9 → `irq` drops after the next edge.
- Auto-reload: write PRESET=3, CTRL=0xB → `irq` is a 1-cycle pulse first after edge E+5, then every 6 cycles for at least 4 periods.
- Mask: repeat the auto-reload case with CTRL=0x3 (IM=0) → `irq` stays 0 while COUNT still cycles 3..1. Setting IM during a one-shot INT hold raises `irq` immediately.
- Stop mid-count: PRESET=100, enable, then write CTRL=0 when COUNT=50 → COUNT freezes at 49 and state returns to IDLE. Re-enable → COUNT reloads to 100.
- Collision and edges:
  - CTRL write of 0x9 in the INT-state cycle (mode 0) → EN stays 1 and the timer restarts.
  - PRESET=0 → INT reached at E+3.
  - Writes to COUNT and reserved addresses → no effect; both read as before (reserved reads 0).

Source files
------------

// File: rtl/tc_pkg.sv
// tc_pkg: shared encodings and register map for the tc_timer block
package tc_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  typedef enum logic [1:0] {MODE_ONESHOT = 2'b00, MODE_RELOAD = 2'b01} mode_t;
  localparam logic [1:0] ADDR_CTRL = 2'b00;
  localparam logic [1:0] ADDR_PRESET = 2'b01;
  localparam logic [1:0] ADDR_COUNT = 2'b10;
  localparam int EN_BIT = 0;
  localparam int MODE_LO = 1;
  localparam int MODE_HI = 2;
  localparam int IM_BIT = 3;
endpackage

// File: rtl/tc_timer.sv
// tc_timer: memory-mapped down-counting timer with one-shot or auto-reload interrupt
module tc_timer
  import tc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);
  state_t state, state_n;
  logic [3:0] ctrl;
  logic [31:0] preset, count, count_n;
  logic irq_flag, flag_n, en_clr, en, reload;
  logic [1:0] sel;
  logic unused;
  assign unused = ^{addr[31:4], din[31:4]};
  assign sel = addr[3:2];
  assign en = ctrl[EN_BIT];
  assign reload = ctrl[MODE_HI:MODE_LO] == MODE_RELOAD;
  assign irq = irq_flag & ctrl[IM_BIT];
  always_comb begin
    state_n = state;
    count_n = count;
    flag_n = irq_flag;
    en_clr = 1'b0;
    case (state)
      IDLE: if (en) begin
        state_n = LOAD;
        flag_n = 1'b0;
      end
      LOAD: begin
        count_n = preset;
        state_n = CNT;
      end
      CNT: if (!en) state_n = IDLE;
        else if (count > 32'd1) count_n = count - 32'd1;
        else begin
          count_n = '0;
          flag_n = 1'b1;
          state_n = INT;
        end
      default: begin
        state_n = IDLE;
        flag_n = reload ? 1'b0 : irq_flag;
        en_clr = !reload;
      end
    endcase
  end
  // a CTRL bus write in the INT cycle takes precedence over the one-shot EN clear
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ctrl <= '0;
      preset <= '0;
      count <= '0;
      irq_flag <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      irq_flag <= flag_n;
      if (we && sel == ADDR_CTRL) ctrl <= din[3:0];
      else if (en_clr) ctrl[EN_BIT] <= 1'b0;
      if (we && sel == ADDR_PRESET) preset <= din;
    end
  end
  always_comb
    dout = (sel == ADDR_CTRL) ? {28'd0, ctrl} :
           (sel == ADDR_PRESET) ? preset :
           (sel == ADDR_COUNT) ? count : '0;
endmodule

// File: tb/tb_tc_timer.sv
// tb_tc_timer: directed and randomized checks of tc_timer against a timeline model
module tb_tc_timer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:2] addr = '0;
  logic we = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic irq;
  int n_cmp = 0;
  int n_err = 0;

  tc_timer dut (.clk(clk), .reset(reset), .addr(addr), .we(we), .din(din), .dout(dout), .irq(irq));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = {28'd0, a};
    #1;
    d = dout;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = {28'd0, a};
    din = d;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 4; i++) chk_reg(tag, i[1:0], 32'd0);
    chk({tag, "_irq"}, {31'd0, irq}, 32'd0);
  endtask

  task automatic stop();
    wr(2'b00, 32'd0);
    repeat (3) cyc();
  endtask

  // Expected behaviour from the enable edge E: INT lands at E+T, repeats every P in reload mode
  task automatic run_trial(input int n, input int mode, input bit im, input int periods);
    int m, t_int, per, len, u;
    logic [3:0] c;
    logic [31:0] e_cnt, e_ctrl;
    logic e_irq;
    bit rl;
    m = (n < 1) ? 1 : n;
    t_int = m + 2;
    per = m + 3;
    len = t_int + periods * per + 1;
    rl = (mode == 1);
    c = {im, mode[1:0], 1'b1};
    stop();
    wr(2'b01, n);
    wr(2'b00, {28'd0, c});
    for (int t = 1; t <= len; t++) begin
      cyc();
      e_ctrl = {28'd0, c};
      if (t < t_int) begin
        e_irq = 1'b0;
        e_cnt = (n - (t - 2) > 0) ? n - (t - 2) : 0;
      end else if (!rl) begin
        e_irq = im;
        e_cnt = 0;
        if (t > t_int) e_ctrl[0] = 1'b0;
      end else begin
        u = (t - t_int) % per;
        e_irq = im && (u == 0);
        e_cnt = (u < 3) ? 0 : n - (u - 3);
      end
      if (t >= 2) chk_reg($sformatf("count n=%0d m=%0d t=%0d", n, mode, t), 2'b10, e_cnt);
      chk_reg($sformatf("ctrl n=%0d m=%0d t=%0d", n, mode, t), 2'b00, e_ctrl);
      chk($sformatf("irq n=%0d m=%0d t=%0d", n, mode, t), {31'd0, irq}, {31'd0, e_irq});
    end
  endtask

  initial begin
    // reset held for two edges while the bus throws random writes at it
    for (int i = 0; i < 2; i++) begin
      we = 1'b1;
      addr = $urandom;
      din = $urandom;
      @(posedge clk);
      #1;
      we = 1'b0;
      chk_zero("reset");
    end
    reset = 1'b0;
    cyc();
    chk_zero("post_reset");

    run_trial(5, 0, 1'b1, 1);
    wr(2'b00, 32'h9);
    chk("rearm_irq_hold", {31'd0, irq}, 32'd1);
    cyc();
    chk("rearm_irq_drop", {31'd0, irq}, 32'd0);
    cyc();
    chk_reg("rearm_count", 2'b10, 32'd5);

    run_trial(3, 1, 1'b1, 4);
    run_trial(3, 1, 1'b0, 4);

    run_trial(4, 0, 1'b0, 1);
    wr(2'b00, 32'h8);
    chk("im_late_irq", {31'd0, irq}, 32'd1);
    chk_reg("im_late_ctrl", 2'b00, 32'h8);

    stop();
    wr(2'b01, 32'd100);
    wr(2'b00, 32'h1);
    repeat (52) @(posedge clk);
    #1;
    chk_reg("stop_pre", 2'b10, 32'd50);
    wr(2'b00, 32'h0);
    chk_reg("stop_edge", 2'b10, 32'd49);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_reg("stop_hold", 2'b10, 32'd49);
    end
    wr(2'b10, 32'hdead_beef);
    wr(2'b11, 32'h1234_5678);
    chk_reg("ro_count", 2'b10, 32'd49);
    chk_reg("ro_rsvd", 2'b11, 32'd0);
    chk_reg("ro_preset", 2'b01, 32'd100);
    chk_reg("ro_ctrl", 2'b00, 32'd0);
    wr(2'b00, 32'h1);
    cyc();
    cyc();
    chk_reg("reenable_count", 2'b10, 32'd100);

    stop();
    wr(2'b01, 32'd2);
    wr(2'b00, 32'h9);
    repeat (4) @(posedge clk);
    #1;
    chk("coll_int", {31'd0, irq}, 32'd1);
    wr(2'b00, 32'h9);
    chk_reg("coll_ctrl", 2'b00, 32'h9);
    chk("coll_irq_hold", {31'd0, irq}, 32'd1);
    cyc();
    chk("coll_irq_clr", {31'd0, irq}, 32'd0);
    cyc();
    chk_reg("coll_cnt2", 2'b10, 32'd2);
    cyc();
    chk_reg("coll_cnt1", 2'b10, 32'd1);
    chk("coll_irq_lo", {31'd0, irq}, 32'd0);
    cyc();
    chk("coll_irq_again", {31'd0, irq}, 32'd1);
    cyc();
    chk_reg("coll_en_clr", 2'b00, 32'h8);

    run_trial(0, 0, 1'b1, 1);
    run_trial(1, 1, 1'b1, 3);

    stop();
    wr(2'b01, 32'd20);
    wr(2'b00, 32'hb);
    repeat (6) cyc();
    reset = 1'b1;
    we = 1'b1;
    addr = {28'd0, 2'b01};
    din = $urandom;
    @(posedge clk);
    #1;
    reset = 1'b0;
    we = 1'b0;
    chk_zero("reset_mid");
    run_trial(2, 0, 1'b1, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk_zero("reset_pending");
    cyc();
    chk_zero("reset_after");

    for (int k = 0; k < 12; k++)
      run_trial($urandom_range(0, 12), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
